// File: rtl/acc_scheduler.sv
// acc_scheduler: round-robin sharing of one accumulator among R requesters.
// Define ACC_SCHED_TIMEOUT_EN to abort jobs that wait TIMEOUT cycles for acc_ready.
module acc_scheduler #(
  parameter int m       = 4,
  parameter int n       = 4,
  parameter int k       = 10,
  parameter int R       = 4,
  parameter int TIMEOUT = 64,
  localparam int width  = m + n,
  localparam int swidth = $clog2(k * (2**(m+n) - 1)),
  localparam int iwidth = $clog2(R)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [R-1:0]         req,
  input  logic [R*k*width-1:0] req_din,
  output logic [R-1:0]         gnt,
  output logic [R-1:0]         done,
  output logic [swidth-1:0]    res_sum,
  output logic [iwidth-1:0]    res_id,
  output logic                 err,
  output logic                 busy,
  output logic                 acc_pl,
  output logic [k*width-1:0]   acc_din,
  input  logic                 acc_ready,
  input  logic [swidth-1:0]    acc_sum
);

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_e;

  state_e              state_q, state_d;
  logic [iwidth-1:0]   ptr_q, ptr_d;
  logic [iwidth-1:0]   cur_q, cur_d;
  logic [k*width-1:0]  opnd_q, opnd_d;
  logic [R-1:0]        gnt_q, gnt_d;
  logic [R-1:0]        done_q, done_d;
  logic [swidth-1:0]   sum_q, sum_d;
  logic [iwidth-1:0]   id_q, id_d;
  logic                err_q, err_d;
  logic                pl_q, pl_d;

  logic                found;
  logic [iwidth-1:0]   win;
  logic [iwidth-1:0]   idx;
  logic                tmo;

  // Search upward from ptr, wrapping, for the first active request.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < R; i++) begin
      if (int'(ptr_q) + i >= R)
        idx = iwidth'(int'(ptr_q) + i - R);
      else
        idx = iwidth'(int'(ptr_q) + i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

`ifdef ACC_SCHED_TIMEOUT_EN
  localparam int cwidth = $clog2(TIMEOUT + 1);

  logic [cwidth-1:0] cnt_q, cnt_d;

  assign tmo = (cnt_q == cwidth'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE)
      cnt_d = '0;
    else if (state_q == RUN)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cur_d   = cur_q;
    opnd_d  = opnd_q;
    gnt_d   = '0;
    done_d  = '0;
    sum_d   = sum_q;
    id_d    = id_q;
    err_d   = 1'b0;
    pl_d    = pl_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = RUN;
          cur_d      = win;
          opnd_d     = req_din[int'(win)*k*width +: k*width];
          gnt_d[win] = 1'b1;
          pl_d       = 1'b1;
        end
      end
      RUN: begin
        if (acc_ready || tmo) begin
          state_d      = GAP;
          sum_d        = acc_ready ? acc_sum : '0;
          err_d        = !acc_ready;
          id_d         = cur_q;
          done_d[cur_q] = 1'b1;
          pl_d         = 1'b0;
          ptr_d        = (cur_q == iwidth'(R-1)) ? '0 : cur_q + 1'b1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cur_q   <= '0;
      opnd_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      sum_q   <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
      pl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      opnd_q  <= opnd_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
      err_q   <= err_d;
      pl_q    <= pl_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign res_sum = sum_q;
  assign res_id  = id_q;
  assign err     = err_q;
  assign busy    = (state_q != IDLE);
  assign acc_pl  = pl_q;
  assign acc_din = opnd_q;

endmodule
